// File: rtl/gpio_cmd_sequencer_pkg.sv
// Shared definitions for the 3-bit-opcode GPIO command protocol:
// opcodes, sequencer state encoding, field widths and the command payload.
package gpio_cmd_sequencer_pkg;

  localparam int unsigned CTRL_W = 3;
  localparam int unsigned DIN_W  = 24;
  localparam int unsigned DOUT_W = 32;

  localparam logic [CTRL_W-1:0] CMD_KERNEL  = 3'd0;
  localparam logic [CTRL_W-1:0] CMD_IMGSIZE = 3'd1;
  localparam logic [CTRL_W-1:0] CMD_IMG     = 3'd2;
  localparam logic [CTRL_W-1:0] CMD_REQ     = 3'd3;
  localparam logic [CTRL_W-1:0] CMD_RUN     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_GAP    = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] code;
    logic [DIN_W-1:0]  data;
  } gpio_cmd_t;

  // A data request is only meaningful once the control block reports end-of-process.
  function automatic logic cmd_legal(input logic [CTRL_W-1:0] code, input logic eop);
    return (code <= CMD_RUN) && !((code == CMD_REQ) && !eop);
  endfunction

endpackage

// File: rtl/gpio_strobe_timer.sv
// Loadable down-counter that parks at zero; zero_c flags the terminal count.
module gpio_strobe_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/gpio_cmd_sequencer.sv
// GPIO command initiator: sequences setup/strobe/gap timing toward the
// convolution control block and captures readback words for data requests.
module gpio_cmd_sequencer
  import gpio_cmd_sequencer_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GAP_CYC   = 1,
  parameter int unsigned READ_LAT  = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              i_CLK,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [CTRL_W-1:0] i_cmd_code,
  input  logic [DIN_W-1:0]  i_cmd_data,
  output logic [CTRL_W-1:0] o_GPIOctrl,
  output logic [DIN_W-1:0]  o_GPIOdata,
  output logic              o_GPIOvalid,
  input  logic [DOUT_W-1:0] i_GPIOdata,
  input  logic              i_EOP,
  output logic              o_rsp_valid,
  output logic [DOUT_W-1:0] o_rsp_data,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_LAT - 1);

  if (SETUP_CYC < 1 || HOLD_CYC < 1 || GAP_CYC < 1) begin : g_bad_timing
    $error("SETUP_CYC, HOLD_CYC and GAP_CYC must each be at least 1");
  end
  if (READ_LAT < 2) begin : g_bad_read_lat
    $error("READ_LAT must be at least 2");
  end
  if ((64'(1) << CNT_W) <= 64'(SETUP_CYC) || (64'(1) << CNT_W) <= 64'(HOLD_CYC) ||
      (64'(1) << CNT_W) <= 64'(GAP_CYC)   || (64'(1) << CNT_W) <= 64'(READ_LAT)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured cycle counts");
  end

  seq_state_t       state, state_d;
  gpio_cmd_t        gpio_q, gpio_d;
  logic             accept_c, legal_c, is_req_c;
  logic             st_load, st_zero, rd_load, rd_zero, rd_active, capture_c;
  logic [CNT_W-1:0] st_val;
  logic             valid_d, rsp_valid_d, err_d, busy_d, ready_d;
  logic [DOUT_W-1:0] rsp_data_d;

  assign accept_c  = i_cmd_valid && o_cmd_ready;
  assign legal_c   = cmd_legal(i_cmd_code, i_EOP);
  assign is_req_c  = (gpio_q.code == CMD_REQ);
  assign capture_c = rd_active && rd_zero;

  gpio_strobe_timer #(.CNT_W(CNT_W)) u_state_timer (
    .clk(i_CLK), .rst(i_rst), .load(st_load), .load_val(st_val), .zero_c(st_zero)
  );

  // Counts from the valid rising edge independently of state so a short
  // READ_LAT can land inside HOLD.
  gpio_strobe_timer #(.CNT_W(CNT_W)) u_read_timer (
    .clk(i_CLK), .rst(i_rst), .load(rd_load), .load_val(READ_LD), .zero_c(rd_zero)
  );

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    st_load = 1'b0;
    st_val  = '0;
    rd_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c && legal_c) begin
          state_d = ST_SETUP;
          st_load = 1'b1;
          st_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (st_zero) begin
          state_d = ST_HOLD;
          st_load = 1'b1;
          st_val  = HOLD_LD;
          rd_load = is_req_c;
        end
      end
      ST_HOLD: begin
        if (st_zero) begin
          if (is_req_c && rd_active && !capture_c) begin
            state_d = ST_RDWAIT;
          end else begin
            state_d = ST_GAP;
            st_load = 1'b1;
            st_val  = GAP_LD;
          end
        end
      end
      ST_RDWAIT: begin
        if (capture_c) begin
          state_d = ST_GAP;
          st_load = 1'b1;
          st_val  = GAP_LD;
        end
      end
      ST_GAP: begin
        if (st_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gpio_d      = gpio_q;
    valid_d     = (state_d == ST_HOLD);
    rsp_valid_d = 1'b0;
    rsp_data_d  = o_rsp_data;
    err_d       = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    ready_d     = (state_d == ST_IDLE);
    if (state == ST_IDLE && accept_c) begin
      if (legal_c) begin
        gpio_d = '{code: i_cmd_code, data: i_cmd_data};
      end else begin
        err_d = 1'b1;
      end
    end
    if (capture_c) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = i_GPIOdata;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      gpio_q      <= '0;
      o_GPIOvalid <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
      o_cmd_ready <= 1'b1;
      rd_active   <= 1'b0;
    end else begin
      gpio_q      <= gpio_d;
      o_GPIOvalid <= valid_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_data  <= rsp_data_d;
      o_err       <= err_d;
      o_busy      <= busy_d;
      o_cmd_ready <= ready_d;
      if (rd_load) begin
        rd_active <= 1'b1;
      end else if (capture_c) begin
        rd_active <= 1'b0;
      end
    end
  end

  assign o_GPIOctrl = gpio_q.code;
  assign o_GPIOdata = gpio_q.data;

endmodule

// File: tb/tb_gpio_cmd_sequencer.sv
// Bench for gpio_cmd_sequencer: strobe timing, back-to-back commands, readback
// capture, rejections, mid-command reset and a short read latency variant.
module tb_gpio_cmd_sequencer;
  import gpio_cmd_sequencer_pkg::*;

  localparam int unsigned SETUP_CYC = 1;
  localparam int unsigned HOLD_CYC  = 2;
  localparam int unsigned GAP_CYC   = 1;
  localparam int unsigned READ_LAT  = 3;
  localparam int PERIOD_STD = 5;
  localparam int PERIOD_REQ = 6;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_valid2;
  logic [2:0]  cmd_code;
  logic [23:0] cmd_data;
  logic        eop;
  logic [31:0] gpio_in, gpio_in2;
  logic        cmd_ready, gvalid, rsp_valid, busy, err;
  logic [2:0]  gctrl;
  logic [23:0] gdata;
  logic [31:0] rsp_data;
  logic        cmd_ready2, gvalid2, rsp_valid2, busy2, err2;
  logic [2:0]  gctrl2;
  logic [23:0] gdata2;
  logic [31:0] rsp_data2;

  gpio_cmd_sequencer #(
    .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC), .READ_LAT(READ_LAT), .CNT_W(4)
  ) dut (
    .i_CLK(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_code(cmd_code), .i_cmd_data(cmd_data), .o_GPIOctrl(gctrl), .o_GPIOdata(gdata),
    .o_GPIOvalid(gvalid), .i_GPIOdata(gpio_in), .i_EOP(eop), .o_rsp_valid(rsp_valid),
    .o_rsp_data(rsp_data), .o_busy(busy), .o_err(err)
  );

  gpio_cmd_sequencer #(
    .SETUP_CYC(1), .HOLD_CYC(3), .GAP_CYC(1), .READ_LAT(2), .CNT_W(4)
  ) dut2 (
    .i_CLK(clk), .i_rst(rst), .i_cmd_valid(cmd_valid2), .o_cmd_ready(cmd_ready2),
    .i_cmd_code(cmd_code), .i_cmd_data(cmd_data), .o_GPIOctrl(gctrl2), .o_GPIOdata(gdata2),
    .o_GPIOvalid(gvalid2), .i_GPIOdata(gpio_in2), .i_EOP(eop), .o_rsp_valid(rsp_valid2),
    .o_rsp_data(rsp_data2), .o_busy(busy2), .o_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  code;
    logic [23:0] data;
    logic        eop;
    logic [31:0] rd;
    logic        exp_rej;
  } vec_t;

  int          total, passed, cyc, age, err_pending, rsp2_cnt, low_cnt, accept_cyc;
  gpio_cmd_t   exp_cmd[$];
  logic [31:0] exp_rsp[$];
  gpio_cmd_t   held, last_legal;
  logic        prev_valid, prev_rsp;
  logic [31:0] cur_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock; outputs observed 1ns after the edge and scoreboard updated.
  task automatic tick();
    gpio_cmd_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (gvalid && !prev_valid) begin
      if (exp_cmd.size() == 0) check("valid_rise_expected", 32'd0, 32'd1);
      else begin
        e = exp_cmd.pop_front();
        check("rise_ctrl", 32'(gctrl), 32'(e.code));
        check("rise_data", 32'(gdata), 32'(e.data));
      end
      check("low_before_rise", 32'(low_cnt >= int'(GAP_CYC)), 32'd1);
      held = '{code: gctrl, data: gdata};
      age = 0;
    end else begin
      if (gvalid) check("ctrl_frozen", 32'({gctrl, gdata}), 32'(held));
      age++;
    end
    low_cnt = gvalid ? 0 : low_cnt + 1;
    if (rsp_valid) begin
      check("rsp_single_pulse", 32'(prev_rsp), 32'd0);
      if (exp_rsp.size() == 0) check("rsp_expected", 32'd0, 32'd1);
      else check("rsp_data", rsp_data, exp_rsp.pop_front());
    end
    if (err) begin
      check("err_expected", 32'(err_pending > 0), 32'd1);
      if (err_pending > 0) err_pending--;
    end
    if (rsp_valid2) rsp2_cnt++;
    prev_valid = gvalid;
    prev_rsp   = rsp_valid;
    gpio_in    = (age == int'(READ_LAT) - 1) ? cur_rd : 32'hDEAD_BEEF;
  endtask

  task automatic send_cmd(input logic [2:0] code, input logic [23:0] data, input logic e,
                          input logic [31:0] rd, input logic rej);
    int n;
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_data  = data;
    eop       = e;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (rej) err_pending++;
    else begin
      exp_cmd.push_back('{code: code, data: data});
      if (code == 3'd3) exp_rsp.push_back(rd);
      last_legal = '{code: code, data: data};
    end
    cur_rd = rd;
    tick();
    accept_cyc = cyc;
    cmd_valid = 1'b0;
    eop       = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int prev_acc;
    logic has_prev, prev_rej, prev_req;
    vecs[0] = '{3'd1, 24'd640,     1'b0, 32'h0,        1'b0};
    vecs[1] = '{3'd2, 24'h0000FF,  1'b0, 32'h0,        1'b0};
    vecs[2] = '{3'd2, 24'h000001,  1'b0, 32'h0,        1'b0};
    vecs[3] = '{3'd3, 24'h000000,  1'b1, 32'h00001ABC, 1'b0};
    vecs[4] = '{3'd3, 24'h000000,  1'b0, 32'h0,        1'b1};
    vecs[5] = '{3'd6, 24'h123456,  1'b1, 32'h0,        1'b1};
    vecs[6] = '{3'd4, 24'h000000,  1'b0, 32'h0,        1'b0};
    vecs[7] = '{3'd3, 24'h000002,  1'b1, 32'h00000FED, 1'b0};
    vecs[8] = '{3'd7, 24'h00FFFF,  1'b0, 32'h0,        1'b1};
    vecs[9] = '{3'd0, 24'h123456,  1'b0, 32'h0,        1'b0};

    total = 0; passed = 0; cyc = 0; age = 100; err_pending = 0; rsp2_cnt = 0;
    low_cnt = 100; accept_cyc = 0; prev_valid = 1'b0; prev_rsp = 1'b0;
    held = '0; last_legal = '0; cur_rd = 32'h0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_code = 3'd0; cmd_data = 24'd0;
    eop = 1'b0; gpio_in = 32'hDEAD_BEEF; gpio_in2 = 32'hDEAD_BEEF;

    repeat (3) tick();
    check("rst_ctrl", 32'(gctrl), 32'd0);
    check("rst_data", 32'(gdata), 32'd0);
    check("rst_valid", 32'(gvalid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Single kernel command, edge by edge.
    send_cmd(3'd0, 24'h0A0B0C, 1'b0, 32'h0, 1'b0);
    check("setup_ctrl", 32'(gctrl), 32'd0);
    check("setup_data", 32'(gdata), 32'h0A0B0C);
    check("setup_valid", 32'(gvalid), 32'd0);
    check("setup_busy", 32'(busy), 32'd1);
    check("setup_ready", 32'(cmd_ready), 32'd0);
    tick(); check("hold1_valid", 32'(gvalid), 32'd1);
    tick(); check("hold2_valid", 32'(gvalid), 32'd1);
    tick(); check("gap_valid", 32'(gvalid), 32'd0);
    check("gap_data_kept", 32'(gdata), 32'h0A0B0C);
    tick(); check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Reset while a run command is strobing.
    send_cmd(3'd4, 24'h00ABCD, 1'b0, 32'h0, 1'b0);
    tick();
    check("run_hold_valid", 32'(gvalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 32'(gvalid), 32'd0);
    check("mrst_ctrl", 32'(gctrl), 32'd0);
    check("mrst_data", 32'(gdata), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(cmd_ready), 32'd1);

    // Table: back-to-back commands, period and rejection checks.
    has_prev = 1'b0; prev_rej = 1'b0; prev_req = 1'b0; prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      send_cmd(vecs[i].code, vecs[i].data, vecs[i].eop, vecs[i].rd, vecs[i].exp_rej);
      if (has_prev)
        check($sformatf("period_v%0d", i), 32'(accept_cyc - prev_acc),
              32'(prev_rej ? 1 : (prev_req ? PERIOD_REQ : PERIOD_STD)));
      if (vecs[i].exp_rej) begin
        check($sformatf("rej_valid_v%0d", i), 32'(gvalid), 32'd0);
        check($sformatf("rej_ctrl_v%0d", i), 32'({gctrl, gdata}), 32'(last_legal));
      end
      has_prev = 1'b1;
      prev_acc = accept_cyc;
      prev_rej = vecs[i].exp_rej;
      prev_req = (vecs[i].code == 3'd3) && !vecs[i].exp_rej;
    end
    repeat (10) tick();
    check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    check("err_all_seen", 32'(err_pending), 32'd0);

    // Short read latency: capture lands inside HOLD at rising edge + 2.
    cmd_code = 3'd3; cmd_data = 24'h000001; eop = 1'b1;
    cmd_valid2 = 1'b1; rsp2_cnt = 0;
    check("d2_ready", 32'(cmd_ready2), 32'd1);
    tick();
    cmd_valid2 = 1'b0; eop = 1'b0;
    check("d2_busy", 32'(busy2), 32'd1);
    tick(); check("d2_rise", 32'(gvalid2), 32'd1);
    tick(); gpio_in2 = 32'h0000_1555;
    tick(); gpio_in2 = 32'hDEAD_BEEF;
    check("d2_rsp_valid", 32'(rsp_valid2), 32'd1);
    check("d2_rsp_data", rsp_data2, 32'h0000_1555);
    check("d2_in_hold", 32'(gvalid2), 32'd1);
    repeat (8) tick();
    check("d2_one_pulse", 32'(rsp2_cnt), 32'd1);
    check("d2_idle", 32'(cmd_ready2), 32'd1);
    check("d2_valid_low", 32'(gvalid2), 32'd0);
    check("d2_no_err", 32'(err2), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gpio_cmd_sequencer.md
Name: gpio_cmd_sequencer

Overview:
Hardware initiator for the 3-bit-opcode GPIO command protocol that the image-convolution control block decodes. It accepts one command per handshake from a local requester (bench, boot ROM walker or soft-core shim). It drives ctrl/data/valid with the required setup, rising-edge and gap timing, and for Data_request captures the returned pixel word after a fixed latency. It lets the convolution datapath be loaded and unloaded without the MicroBlaze.

Parameters:
SETUP_CYC, 1, cycles ctrl/data are stable with valid low before the valid rising edge (min 1)
HOLD_CYC, 2, cycles o_GPIOvalid stays high (min 1)
GAP_CYC, 1, cycles valid low after a command before the next can start (min 1)
READ_LAT, 3, cycles from the valid rising edge to sampling i_GPIOdata on Data_request (min 2)
CNT_W, 4, counter width; must hold max(SETUP_CYC, HOLD_CYC, GAP_CYC, READ_LAT)

Ports:
i_CLK  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  high only in IDLE
i_cmd_code  in  3  0 kernel, 1 img_size, 2 img pixel, 3 data request, 4 go-to-run; 5-7 illegal
i_cmd_data  in  24  payload (kernel row 24b, size in [9:0], pixel in [7:0])
o_GPIOctrl  out  3  opcode to control block
o_GPIOdata  out  24  payload to control block
o_GPIOvalid  out  1  strobe; the control block acts on its rising edge
i_GPIOdata  in  32  readback word from control block ([12:0] significant)
i_EOP  in  1  end-of-process flag from control block
o_rsp_valid  out  1  one-cycle pulse with readback data
o_rsp_data  out  32  captured readback word
o_busy  out  1  high whenever the state is not IDLE
o_err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset values: o_GPIOctrl=3'd0, o_GPIOdata=0, o_GPIOvalid=0, o_rsp_valid=0, o_rsp_data=0, o_err=0, o_busy=0, o_cmd_ready=1 (IDLE). All outputs are registered.
- States: IDLE, SETUP, HOLD, RDWAIT, GAP.
- IDLE: handshake when i_cmd_valid && o_cmd_ready. Code and data are latched into o_GPIOctrl/o_GPIOdata at that edge.
  - Illegal code (5-7): o_err pulses the next cycle, state stays IDLE, outputs unchanged.
  - Code 3 with i_EOP=0 at accept: rejected the same way.
  - Otherwise go to SETUP and load the counter with SETUP_CYC-1.
- SETUP: valid low. At counter 0, o_GPIOvalid goes high on the next edge and the state moves to HOLD with the counter loaded to HOLD_CYC-1.
- HOLD: valid high, ctrl/data frozen. At counter 0, valid drops.
  - Code 3: go to RDWAIT.
  - All other codes: go to GAP.
- RDWAIT: the counter starts at the valid rising edge. At exactly READ_LAT cycles after the rising edge, i_GPIOdata is captured into o_rsp_data and o_rsp_valid pulses for 1 cycle; then go to GAP. If READ_LAT falls inside HOLD, the capture still happens at READ_LAT, using a shared edge counter rather than a per-state counter. In that case the state goes HOLD→GAP directly after the capture.
- GAP: valid low for GAP_CYC cycles, then IDLE. o_GPIOctrl/o_GPIOdata keep the last values; they do not return to 0.
- Command period = SETUP_CYC+HOLD_CYC+GAP_CYC+1 (IDLE) cycles, except code 3, which takes max(that, READ_LAT+GAP_CYC+SETUP_CYC+1).
- Opcode is never changed while valid is high. Valid is never high on two consecutive commands without at least GAP_CYC low cycles between them.
- i_EOP is sampled only at accept. If i_EOP drops mid-read, the capture still occurs.
- Reset mid-operation: all outputs return to reset values on the next edge; any pending response is discarded.

Decomposition:
- Shared package: opcode localparams (CMD_KERNEL=0, CMD_IMGSIZE=1, CMD_IMG=2, CMD_REQ=3, CMD_RUN=4), state encoding, and GPIO field widths (ctrl 3, data-in 24, data-out 32).
- The control block also uses this package.
- One natural sub-module: gpio_strobe_timer, a down-counter with load/zero flag, instantiated once for the state counter and once for the read-latency edge counter.

Test Plan:
- Reset, then cmd code 0 / data 24'h0A0B0C -> ctrl=0, data=0A0B0C one cycle before valid rises; valid high 2 cycles; ready back after 5 cycles; no rsp.
- Back-to-back codes 1 (10'd640), 2 (8'hFF), 2 (8'h01) with i_cmd_valid held -> three distinct valid rising edges each separated by ≥1 low cycle; ctrl never changes while valid is high.
- Code 3 with i_EOP=1, bench drives i_GPIOdata=32'h00001ABC exactly 3 cycles after valid rises -> o_rsp_valid single pulse, o_rsp_data=00001ABC.
- Code 3 with i_EOP=0, and code 6 -> o_err pulses once each; o_GPIOvalid stays 0; ctrl/data unchanged.
- Assert i_rst during HOLD of a code-4 command -> next cycle valid=0, ctrl=0, busy=0, ready=1; a following command proceeds normally.
- READ_LAT=1 override is illegal (must be rejected at elaboration); READ_LAT=2 with HOLD_CYC=3 -> capture occurs during HOLD at rising edge +2, exactly one rsp pulse.
